// File: rtl/alu_div_restoring.sv
// Sequential unsigned restoring divider: one trial subtraction per clock,
// start/busy/done handshake, registered quotient/remainder/div_by_zero.
module alu_div_restoring #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  // Partial remainder. The top bit of an accepted trial difference is always
  // zero (T < V), and a restore keeps S whose top bit is only set when S > V,
  // so only the low WIDTH bits ever carry information.
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic [WIDTH-1:0] dvd_reg, dvd_next;
  logic [WIDTH-1:0] quo_reg, quo_next;
  logic [WIDTH-1:0] dsr_reg, dsr_next;
  logic             done_reg, done_next;
  logic [WIDTH-1:0] quotient_reg, quotient_next;
  logic [WIDTH-1:0] remainder_reg, remainder_next;
  logic             dbz_reg, dbz_next;

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             borrow;
  logic [WIDTH-1:0] new_q;
  logic [WIDTH:0]   new_r;

  always_comb begin
    shifted = {rem_reg, dvd_reg[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, dsr_reg};
    borrow  = diff[WIDTH+1];
    new_q   = {quo_reg[WIDTH-2:0], ~borrow};
    new_r   = borrow ? shifted : diff[WIDTH:0];
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    rem_next       = rem_reg;
    dvd_next       = dvd_reg;
    quo_next       = quo_reg;
    dsr_next       = dsr_reg;
    done_next      = 1'b0;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    dbz_next       = dbz_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            dvd_next   = dividend;
            dsr_next   = divisor;
            rem_next   = '0;
            quo_next   = '0;
            cnt_next   = '0;
            state_next = RUN;
          end else begin
            done_next      = 1'b1;
            dbz_next       = 1'b1;
            quotient_next  = '1;
            remainder_next = dividend;
          end
        end
      end
      RUN: begin
        dvd_next = {dvd_reg[WIDTH-2:0], 1'b0};
        rem_next = new_r[WIDTH-1:0];
        quo_next = new_q;
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == LAST) begin
          cnt_next       = '0;
          state_next     = IDLE;
          done_next      = 1'b1;
          dbz_next       = 1'b0;
          quotient_next  = new_q;
          remainder_next = new_r[WIDTH-1:0];
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      rem_reg       <= '0;
      dvd_reg       <= '0;
      quo_reg       <= '0;
      dsr_reg       <= '0;
      done_reg      <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      rem_reg       <= rem_next;
      dvd_reg       <= dvd_next;
      quo_reg       <= quo_next;
      dsr_reg       <= dsr_next;
      done_reg      <= done_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
      dbz_reg       <= dbz_next;
    end
  end

  assign busy        = (state_reg == RUN);
  assign done        = done_reg;
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_alu_div_restoring.sv
// Self-checking bench for alu_div_restoring: directed cases, exhaustive
// WIDTH=4 sweep and random WIDTH=8 pairs against a / and % reference model.
module tb_alu_div_restoring;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start4 = 1'b0, start8 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy4, done4, dbz4, busy8, done8, dbz8;
  logic [3:0] q4, r4;
  logic [7:0] q8, r8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_div_restoring #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .dividend(a4), .divisor(b4),
    .busy(busy4), .done(done4), .quotient(q4), .remainder(r4), .div_by_zero(dbz4)
  );

  alu_div_restoring #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .dividend(a8), .divisor(b8),
    .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_by_zero(dbz8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] cur_q(input int w);
    return (w == 4) ? {4'b0, q4} : q8;
  endfunction
  function automatic logic [7:0] cur_r(input int w);
    return (w == 4) ? {4'b0, r4} : r8;
  endfunction
  function automatic logic cur_busy(input int w);
    return (w == 4) ? busy4 : busy8;
  endfunction
  function automatic logic cur_done(input int w);
    return (w == 4) ? done4 : done8;
  endfunction
  function automatic logic cur_dbz(input int w);
    return (w == 4) ? dbz4 : dbz8;
  endfunction

  // Reference: plain unsigned / and %, divide by zero gives all ones and the dividend.
  function automatic logic [7:0] ref_q(input int w, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] ones;
    ones = (w == 4) ? 8'h0F : 8'hFF;
    return (b == 0) ? ones : a / b;
  endfunction
  function automatic logic [7:0] ref_r(input logic [7:0] a, input logic [7:0] b);
    return (b == 0) ? a : a % b;
  endfunction

  task automatic drive(input int w, input logic s, input logic [7:0] a, input logic [7:0] b);
    if (w == 4) begin
      start4 = s; a4 = a[3:0]; b4 = b[3:0];
    end else begin
      start8 = s; a8 = a; b8 = b;
    end
  endtask

  // Called just after a negedge with the DUT idle; returns at the negedge of the done cycle.
  task automatic divide(input int w, input logic [7:0] a, input logic [7:0] b, input bit show);
    int cycles, busy_cycles, exp_cycles;
    drive(w, 1'b1, a, b);
    @(negedge clk);
    drive(w, 1'b0, a, b);
    cycles = 1;
    busy_cycles = 0;
    exp_cycles = (b == 0) ? 1 : w + 1;
    while (!cur_done(w) && cycles < 40) begin
      if (cur_busy(w)) busy_cycles++;
      @(negedge clk);
      cycles++;
    end
    check("done_latency", cycles, exp_cycles);
    check("busy_cycles", busy_cycles, (b == 0) ? 0 : w);
    check("busy_with_done", {31'b0, cur_busy(w)}, 0);
    check("quotient", {24'b0, cur_q(w)}, {24'b0, ref_q(w, a, b)});
    check("remainder", {24'b0, cur_r(w)}, {24'b0, ref_r(a, b)});
    check("div_by_zero", {31'b0, cur_dbz(w)}, {31'b0, (b == 0)});
    if (show)
      $display("div w=%0d %0d/%0d -> q=%0d r=%0d dbz=%0d cycles=%0d",
               w, a, b, cur_q(w), cur_r(w), cur_dbz(w), cycles);
  endtask

  task automatic divide_idle(input int w, input logic [7:0] a, input logic [7:0] b, input bit show);
    divide(w, a, b, show);
    @(negedge clk);
    check("done_pulse_width", {31'b0, cur_done(w)}, 0);
  endtask

  initial begin
    logic [7:0] ra, rb;
    int dc;

    #2;
    check("rst_busy", {31'b0, busy4}, 0);
    check("rst_done", {31'b0, done4}, 0);
    check("rst_quotient", {28'b0, q4}, 0);
    check("rst_remainder", {28'b0, r4}, 0);
    check("rst_dbz", {31'b0, dbz4}, 0);
    check("rst_busy8", {31'b0, busy8}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    divide_idle(4, 8'd13, 8'd4, 1'b1);
    divide_idle(4, 8'd15, 8'd1, 1'b1);
    divide_idle(4, 8'd3, 8'd9, 1'b1);
    divide_idle(4, 8'd0, 8'd5, 1'b1);
    divide_idle(4, 8'd7, 8'd0, 1'b1);
    divide_idle(4, 8'd8, 8'd2, 1'b1);

    // start during busy is ignored; operands are not resampled
    drive(4, 1'b1, 8'd13, 8'd4);
    @(negedge clk);
    drive(4, 1'b0, 8'd13, 8'd4);
    @(negedge clk);
    drive(4, 1'b1, 8'd9, 8'd2);
    @(negedge clk);
    drive(4, 1'b0, 8'd9, 8'd2);
    dc = 3;
    while (!done4 && dc < 40) begin
      @(negedge clk);
      dc++;
    end
    check("ignored_latency", dc, 5);
    check("ignored_quotient", {28'b0, q4}, 3);
    check("ignored_remainder", {28'b0, r4}, 1);
    $display("busy-start 13/4 with 9/2 mid-run -> q=%0d r=%0d", q4, r4);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("ignored_no_done", {31'b0, done4}, 0);
      check("ignored_hold_q", {28'b0, q4}, 3);
    end

    // back-to-back: second start issued in the done cycle
    divide(4, 8'd12, 8'd5, 1'b1);
    divide_idle(4, 8'd14, 8'd3, 1'b1);

    // reset in the second RUN cycle aborts the division
    drive(4, 1'b1, 8'd11, 8'd3);
    @(negedge clk);
    drive(4, 1'b0, 8'd11, 8'd3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy4}, 0);
    check("abort_quotient", {28'b0, q4}, 0);
    check("abort_remainder", {28'b0, r4}, 0);
    check("abort_dbz", {31'b0, dbz4}, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", {31'b0, done4}, 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_late_done", {31'b0, done4}, 0);
    end
    $display("reset abort of 11/3 -> outputs cleared");
    divide_idle(4, 8'd11, 8'd3, 1'b1);

    // exhaustive WIDTH=4 sweep
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        divide_idle(4, 8'(a), 8'(b), 1'b0);
    $display("sweep w=4 all 256 pairs done");

    // random WIDTH=8 pairs, including some zero divisors
    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = (($urandom & 15) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      divide_idle(8, ra, rb, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
